// File: rtl/alarm_sequencer.sv
// Alarm path of the digital clock: stores the alarm time, detects the comparator's
// rising match and runs the ring / snooze / stop state machine for the buzzer.
module alarm_sequencer #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       alarm_en,
  input  logic       set_valid,
  output logic       set_ready,
  input  logic [7:0] set_hour,
  input  logic [7:0] set_min,
  input  logic [7:0] set_sec,
  output logic       set_err,
  output logic [7:0] alm_hour,
  output logic [7:0] alm_min,
  output logic [7:0] alm_sec,
  input  logic       cmp_equal,
  input  logic       stop_btn,
  input  logic       snooze_btn,
  output logic       ring,
  output logic       beep,
  output logic [1:0] state,
  output logic [3:0] snooze_used
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } state_t;

  localparam logic [15:0] RING_LIM   = 16'(RING_SECS);
  localparam logic [15:0] SNOOZE_LIM = 16'(SNOOZE_SECS);
  localparam logic [3:0]  SNZ_MAX    = 4'(MAX_SNOOZE);

  state_t      r_state, w_state_n;
  logic [15:0] r_cnt, w_cnt_n, w_cnt_inc;
  logic        r_beep, w_beep_n;
  logic [3:0]  r_used, w_used_n;
  logic        r_eq_q, r_load_q, r_set_err, r_ring, r_set_ready;
  logic [7:0]  r_alm_hour, r_alm_min, r_alm_sec;
  logic        w_xfer, w_time_ok, w_trig;

  assign w_xfer    = set_valid & r_set_ready;
  assign w_time_ok = (set_hour < 8'd24) && (set_min < 8'd60) && (set_sec < 8'd60);
  // A match that appears only because a new alarm time was just loaded is not an alarm.
  assign w_trig    = cmp_equal & ~r_eq_q & ~r_load_q;
  assign w_cnt_inc = r_cnt + 16'd1;

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_beep_n  = r_beep;
    w_used_n  = r_used;
    if (!alarm_en) begin
      w_state_n = IDLE;
      w_beep_n  = 1'b0;
      w_used_n  = 4'd0;
      w_cnt_n   = 16'd0;
    end else begin
      unique case (r_state)
        IDLE: w_state_n = ARMED;
        ARMED: begin
          if (w_trig) begin
            w_state_n = RINGING;
            w_cnt_n   = 16'd0;
            w_beep_n  = 1'b1;
            w_used_n  = 4'd0;
          end
        end
        RINGING: begin
          if (stop_btn) begin
            w_state_n = ARMED;
            w_beep_n  = 1'b0;
          end else if (snooze_btn) begin
            w_beep_n = 1'b0;
            if (r_used < SNZ_MAX) begin
              w_state_n = SNOOZE;
              w_used_n  = r_used + 4'd1;
              w_cnt_n   = 16'd0;
            end else begin
              w_state_n = ARMED;
            end
          end else if (tick_1hz) begin
            w_cnt_n  = w_cnt_inc;
            w_beep_n = ~r_beep;
            if (w_cnt_inc == RING_LIM) begin
              w_state_n = ARMED;
              w_beep_n  = 1'b0;
            end
          end
        end
        SNOOZE: begin
          if (stop_btn) begin
            w_state_n = ARMED;
          end else if (tick_1hz) begin
            w_cnt_n = w_cnt_inc;
            if (w_cnt_inc == SNOOZE_LIM) begin
              w_state_n = RINGING;
              w_cnt_n   = 16'd0;
              w_beep_n  = 1'b1;
            end
          end
        end
        default: w_state_n = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= 16'd0;
      r_beep      <= 1'b0;
      r_used      <= 4'd0;
      r_eq_q      <= 1'b1;  // time and alarm both read midnight after reset: no edge there
      r_load_q    <= 1'b0;
      r_set_err   <= 1'b0;
      r_ring      <= 1'b0;
      r_set_ready <= 1'b1;
      r_alm_hour  <= 8'd0;
      r_alm_min   <= 8'd0;
      r_alm_sec   <= 8'd0;
    end else begin
      r_state     <= w_state_n;
      r_cnt       <= w_cnt_n;
      r_beep      <= w_beep_n;
      r_used      <= w_used_n;
      r_eq_q      <= cmp_equal;
      r_load_q    <= w_xfer & w_time_ok;
      r_set_err   <= w_xfer & ~w_time_ok;
      r_ring      <= (w_state_n == RINGING);
      r_set_ready <= (w_state_n == IDLE) || (w_state_n == ARMED);
      if (w_xfer && w_time_ok) begin
        r_alm_hour <= set_hour;
        r_alm_min  <= set_min;
        r_alm_sec  <= set_sec;
      end
    end
  end

  assign set_ready   = r_set_ready;
  assign set_err     = r_set_err;
  assign alm_hour    = r_alm_hour;
  assign alm_min     = r_alm_min;
  assign alm_sec     = r_alm_sec;
  assign ring        = r_ring;
  assign beep        = r_beep;
  assign state       = r_state;
  assign snooze_used = r_used;

endmodule
